uart_tx_arbiter: RTL

Shares the single write port of the UART TX peripheral (byte data, write-valid, FIFO-full) between NUM_REQ byte-stream requesters, e.g. M-mode and S-mode console writers. Arbitration is round-robin with line-atomic locking: once granted, a requester owns the port until it sends LINE_END, hits MAX_BURST bytes, or goes idle for IDLE_TIMEOUT cycles. Lines from different requesters never interleave on the serial output. Sits between the requesters and the peripheral's pdata/valid/fifo_full ports, in the same clock domain as the FIFO write side.

---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/uart_arb_rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX write-port arbiter.
// Holds the FSM state enum and the default line terminator byte.
package uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } uart_arb_state_e;

  localparam logic [7:0] UART_ARB_LINE_END = 8'h0A;

endpackage

// File: rtl/uart_arb_rr_picker.sv
// Round-robin picker: first valid index after last_owner, wrapping.
// Ports: valid (NUM_REQ), last_owner (idx) -> winner (idx), any_valid.
module uart_arb_rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      last_owner,
  output logic [IW-1:0]      winner,
  output logic               any_valid
);
  import uart_arb_pkg::*;

  int idx;

  // Walk offsets from farthest to nearest so the nearest
  // valid requester after last_owner is the final assignment.
  always_comb begin
    winner    = last_owner;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_owner) + i) % NUM_REQ;
      if (valid[idx]) begin
        winner    = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port among NUM_REQ byte streams.
// Round-robin grants, held until LINE_END, MAX_BURST bytes or idle.
// Ports: clk/rst (sync, active-high); req_valid/req_data/req_ready
// per requester; fifo_full in; tx_pdata/tx_valid out; grant; busy.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ      = 2,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 16,
  parameter logic [7:0] LINE_END     = UART_ARB_LINE_END
) (
  input  logic                 i_uart_arb_clk,
  input  logic                 i_uart_arb_rst,
  input  logic [NUM_REQ-1:0]   i_uart_arb_req_valid,
  input  logic [NUM_REQ*8-1:0] i_uart_arb_req_data,
  output logic [NUM_REQ-1:0]   o_uart_arb_req_ready,
  input  logic                 i_uart_arb_fifo_full,
  output logic [7:0]           o_uart_arb_tx_pdata,
  output logic                 o_uart_arb_tx_valid,
  output logic [NUM_REQ-1:0]   o_uart_arb_grant,
  output logic                 o_uart_arb_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  uart_arb_state_e    state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [TW-1:0]      idle_q, idle_d;

  logic [7:0]    req_data [NUM_REQ];
  logic [IW-1:0] winner;
  logic          any_valid;
  logic          locked;
  logic          own_valid;
  logic [7:0]    own_data;
  logic          xfer;
  logic          release_now;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign req_data[r] = i_uart_arb_req_data[r*8 +: 8];
  end

  uart_arb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid      (i_uart_arb_req_valid),
    .last_owner (last_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // While locked, last_q is the current owner.
  assign locked    = (state_q == ARB_LOCKED);
  assign own_valid = i_uart_arb_req_valid[last_q];
  assign own_data  = req_data[last_q];

  always_comb begin
    o_uart_arb_req_ready = '0;
    o_uart_arb_tx_valid  = 1'b0;
    o_uart_arb_tx_pdata  = 8'h00;
    if (locked) begin
      o_uart_arb_req_ready[last_q] = !i_uart_arb_fifo_full;
      o_uart_arb_tx_valid = own_valid && !i_uart_arb_fifo_full;
      o_uart_arb_tx_pdata = own_data;
    end
  end

  assign xfer = o_uart_arb_tx_valid;

  // Compare against limit-1 so the counters never need to
  // hold the limit itself; all causes fold into one release.
  always_comb begin
    release_now = 1'b0;
    if (xfer && (own_data == LINE_END))
      release_now = 1'b1;
    if (xfer && (burst_q == BW'(MAX_BURST - 1)))
      release_now = 1'b1;
    if (locked && !own_valid &&
        (idle_q == TW'(IDLE_TIMEOUT - 1)))
      release_now = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          state_d         = ARB_LOCKED;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          last_d          = winner;
          burst_d         = '0;
          idle_d          = '0;
        end
      end
      ARB_LOCKED: begin
        if (release_now) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end else if (xfer) begin
          burst_d = burst_q + 1'b1;
          idle_d  = '0;
        end else if (own_valid) begin
          idle_d  = '0;
        end else begin
          idle_d  = idle_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_uart_arb_clk) begin
    if (i_uart_arb_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

  assign o_uart_arb_grant = grant_q;
  assign o_uart_arb_busy  = locked;

endmodule
